// File: rtl/mem_resp_pipe.sv
// Fixed-latency response pipeline for the SRAM responder.
// Shifts {valid, err, rdata} through Latency register stages; stage 1 is
// loaded every cycle and the response outputs come from the last stage.
// All stages, including data, clear asynchronously on reset, so in-flight
// responses are lost and idle data reads '0 afterwards.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   load_valid  response valid entering stage 1
//   load_err    response error entering stage 1
//   load_rdata  response data entering stage 1
//   resp_valid  valid from the last stage
//   resp_err    error from the last stage
//   resp_rdata  data from the last stage
module mem_resp_pipe #(
    parameter int unsigned Latency   = 1,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_valid,
    input  logic                 load_err,
    input  logic [DataWidth-1:0] load_rdata,
    output logic                 resp_valid,
    output logic                 resp_err,
    output logic [DataWidth-1:0] resp_rdata
);

    logic [Latency-1:0]                valid_q;
    logic [Latency-1:0]                err_q;
    logic [Latency-1:0][DataWidth-1:0] rdata_q;

    // Chains are one entry longer than the registers: entry 0 is the load
    // value and the top entry is the last register, which avoids a special
    // case for a single-stage pipe.
    logic [Latency:0]                  valid_chain;
    logic [Latency:0]                  err_chain;
    logic [Latency:0][DataWidth-1:0]   rdata_chain;

    always_comb begin
        valid_chain = {valid_q, load_valid};
        err_chain   = {err_q, load_err};
        rdata_chain = {rdata_q, load_rdata};
    end

    // Shift every cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            err_q   <= '0;
            rdata_q <= '0;
        end else begin
            valid_q <= valid_chain[Latency-1:0];
            err_q   <= err_chain[Latency-1:0];
            rdata_q <= rdata_chain[Latency-1:0];
        end
    end

    assign resp_valid = valid_chain[Latency];
    assign resp_err   = err_chain[Latency];
    assign resp_rdata = rdata_chain[Latency];

endmodule

// File: rtl/mem_resp_sram.sv
// Memory-side responder: valid/ready requests in, valid-only responses out
// a fixed Latency cycles after acceptance. Holds a flop storage array with
// byte-enable writes, optionally zero-filled one word per cycle after reset.
//
// Ports:
//   clk_i             clock, rising edge
//   rst_i             asynchronous active-high reset
//   mem_req_addr_i    word address
//   mem_req_we_i      1 = write, 0 = read
//   mem_req_be_i      byte enables for writes
//   mem_req_wdata_i   write data
//   mem_req_valid_i   request valid
//   mem_req_ready_o   request can be accepted (registered)
//   mem_resp_rdata_o  read data; '0 for writes and errors
//   mem_resp_err_o    address out of range
//   mem_resp_valid_o  response valid; no backpressure
module mem_resp_sram #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Latency   = 1,
    parameter bit          InitZero  = 1'b1,
    parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [AddrWidth-1:0]   mem_req_addr_i,
    input  logic                   mem_req_we_i,
    input  logic [DataWidth/8-1:0] mem_req_be_i,
    input  logic [DataWidth-1:0]   mem_req_wdata_i,
    input  logic                   mem_req_valid_i,
    output logic                   mem_req_ready_o,
    output logic [DataWidth-1:0]   mem_resp_rdata_o,
    output logic                   mem_resp_err_o,
    output logic                   mem_resp_valid_o
);

    localparam int unsigned BeWidth  = DataWidth / 8;
    localparam int unsigned CntWidth = AddrWidth + 1;
    localparam logic [CntWidth-1:0] LastWord = CntWidth'(NumWords - 1);
    localparam logic [CntWidth-1:0] WordCount = CntWidth'(NumWords);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    localparam state_e ResetState = InitZero ? ST_INIT : ST_RUN;

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  clr_we;
    logic                  ready_q;

    logic                  accept;
    logic                  in_range;
    logic                  mem_we;
    logic [AddrWidth-1:0]  mem_waddr;
    logic [BeWidth-1:0]    mem_wbe;
    logic [DataWidth-1:0]  mem_wdata;
    logic [DataWidth-1:0]  mem_q [NumWords];

    logic                  load_valid;
    logic                  load_err;
    logic [DataWidth-1:0]  load_rdata;

    // State, init counter and ready register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ResetState;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == ST_RUN);
        end
    end

    // Next state: INIT walks every word once, then RUN forever
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            ST_INIT: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + CntWidth'(1);
                if (cnt_q == LastWord) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ResetState;
            end
        endcase
    end

    assign mem_req_ready_o = ready_q;

    // Ready never depends on valid, so acceptance is just the AND
    assign accept   = mem_req_valid_i & ready_q;
    assign in_range = ({1'b0, mem_req_addr_i} < WordCount);

    // Storage write port: zero-fill during INIT, otherwise accepted in-range writes
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = mem_req_addr_i;
        mem_wbe   = mem_req_be_i;
        mem_wdata = mem_req_wdata_i;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q[AddrWidth-1:0];
            mem_wbe   = '1;
            mem_wdata = '0;
        end else if (accept && mem_req_we_i && in_range) begin
            mem_we = 1'b1;
        end
    end

    // Storage has no reset; contents are defined only by INIT or writes
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < int'(BeWidth); b++) begin
                if (mem_wbe[b]) begin
                    mem_q[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Response for this cycle's request; reads see the pre-edge contents
    always_comb begin
        load_valid = accept;
        load_err   = accept & ~in_range;
        load_rdata = '0;
        if (accept && !mem_req_we_i && in_range) begin
            load_rdata = mem_q[mem_req_addr_i];
        end
    end

    mem_resp_pipe #(
        .Latency   (Latency),
        .DataWidth (DataWidth)
    ) u_pipe (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_valid (load_valid),
        .load_err   (load_err),
        .load_rdata (load_rdata),
        .resp_valid (mem_resp_valid_o),
        .resp_err   (mem_resp_err_o),
        .resp_rdata (mem_resp_rdata_o)
    );

endmodule
